// File: rtl/rv_pkg.sv
// Shared RV32I integer-pipeline constants and register-address type.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  typedef logic [$clog2(NREG)-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
module regfile_sb_cnt
  import rv_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat,
  output logic          zero
);
  assign sat  = &cnt;
  assign zero = ~|cnt;

  // inc+dec together cancel; the ends clamp rather than wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && !dec && !sat)   cnt <= cnt + CW'(1);
    else if (dec && !inc && !zero)  cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and per-register pending-write scoreboard.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int CW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_stall,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic                sb_err,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0]          regs [NREG];
  logic [NREG-1:0][CW-1:0]  pend;
  logic [NREG-1:0]          sat_v, zero_v;
  logic                     wb_nz, issue_acc;

  assign wb_nz       = wb_en && (wb_rd != AW'(REG_ZERO));
  assign issue_stall = issue_en && (issue_rd != AW'(REG_ZERO)) && sat_v[issue_rd] &&
                       !(wb_en && wb_rd == issue_rd);
  assign issue_acc   = issue_en && (issue_rd != AW'(REG_ZERO)) && !issue_stall;
  assign busy_vec    = ~zero_v;

  assign pend[0]   = '0;
  assign sat_v[0]  = 1'b0;
  assign zero_v[0] = 1'b1;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    regfile_sb_cnt #(.CW(CW)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (issue_acc && issue_rd == AW'(r)),
      .dec  (wb_en && wb_rd == AW'(r)),
      .clr  (flush),
      .cnt  (pend[r]),
      .sat  (sat_v[r]),
      .zero (zero_v[r])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_nz) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Unmatched write-back: nothing pending and no same-cycle issue to cover it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_err <= 1'b0;
    else if (wb_nz && !flush && zero_v[wb_rd] && !(issue_acc && issue_rd == wb_rd))
      sb_err <= 1'b1;
  end

  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    a       = '0;
    hit     = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a   = rd_addr[k*AW +: AW];
      hit = wb_en && (wb_rd == a) && (a != AW'(REG_ZERO));
      // reset also masks the bypass path so nothing leaks while rst is low
      if (rst) rd_data[k*XLEN +: XLEN] = hit ? wb_data : regs[a];
      rd_busy[k] = (a != AW'(REG_ZERO)) &&
                   ((pend[a] > CW'(1)) || (pend[a] == CW'(1) && !hit));
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against a behavioural scoreboard model, plus directed cases.
module tb_regfile_sb;
  localparam int XLEN = 32, NREG = 32, AW = 5, NRD = 2, CW = 2;
  localparam int PMAX = (1 << CW) - 1;

  logic                clk = 0, rst = 0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                issue_en = 0, wb_en = 0, flush = 0;
  logic [AW-1:0]       issue_rd = '0, wb_rd = '0;
  logic [XLEN-1:0]     wb_data = '0;
  logic                issue_stall, sb_err;
  logic [NREG-1:0]     busy_vec;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .sb_err(sb_err), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int          m_pend [NREG];
  logic [31:0] m_rf   [NREG];
  bit          m_err;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void m_clear();
    for (int r = 0; r < NREG; r++) begin m_pend[r] = 0; m_rf[r] = 0; end
    m_err = 0;
  endfunction

  function automatic logic [AW-1:0] port_addr(int k);
    return rd_addr[k*AW +: AW];
  endfunction

  function automatic logic [31:0] m_rd(int k);
    int a = port_addr(k);
    if (!rst || a == 0) return 0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit m_busy(int k);
    int a = port_addr(k);
    int remaining;
    if (a == 0) return 0;
    remaining = m_pend[a] - ((wb_en && wb_rd == a) ? 1 : 0);
    return remaining > 0;
  endfunction

  function automatic bit m_stall();
    return issue_en && issue_rd != 0 && m_pend[issue_rd] == PMAX && !(wb_en && wb_rd == issue_rd);
  endfunction

  function automatic void m_update();
    bit acc, wbv;
    if (!rst) return;
    acc = issue_en && issue_rd != 0 && !m_stall();
    wbv = wb_en && wb_rd != 0;
    if (wbv) m_rf[wb_rd] = wb_data;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    end else if (acc && wbv && issue_rd == wb_rd) begin
      // cancels out
    end else begin
      if (acc) m_pend[issue_rd]++;
      if (wbv) begin
        if (m_pend[wb_rd] > 0) m_pend[wb_rd]--;
        else m_err = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [NRD-1:0]  eb;
    logic [NREG-1:0] ev;
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], m_rd(k));
      eb[k] = m_busy(k);
    end
    for (int r = 0; r < NREG; r++) ev[r] = rst && m_pend[r] != 0;
    chk("rd_busy", 32'(rd_busy), 32'(eb));
    chk("issue_stall", 32'(issue_stall), 32'(m_stall()));
    chk("busy_vec", busy_vec, ev);
    chk("sb_err", 32'(sb_err), 32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    issue_en = 0; wb_en = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 0; m_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    m_clear();
    do_reset();

    // 1: bypass then stored value
    wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rd_addr[0 +: AW] = 5;
    #1 chk("t1_bypass", rd_data[0 +: XLEN], 32'hDEADBEEF);
    step(); idle();
    #1 chk("t1_stored", rd_data[0 +: XLEN], 32'hDEADBEEF);

    // 2: register zero
    do_reset();
    wb_en = 1; wb_rd = 0; wb_data = 32'h1234; rd_addr = '0;
    #1 chk("t2_rd0", rd_data[0 +: XLEN], 32'h0);
    chk("t2_busy0", 32'(rd_busy), 32'h0);
    step(); idle();
    #1 chk("t2_rd0_after", rd_data[0 +: XLEN], 32'h0);
    chk("t2_sberr", 32'(sb_err), 32'h0);

    // 3: issue then write-back release
    issue_en = 1; issue_rd = 7;
    step(); idle(); rd_addr[AW +: AW] = 7;
    #1 chk("t3_busyvec", 32'(busy_vec[7]), 32'h1);
    chk("t3_rdbusy", 32'(rd_busy[1]), 32'h1);
    wb_en = 1; wb_rd = 7; wb_data = 32'h55;
    #1 chk("t3_rdbusy_wb", 32'(rd_busy[1]), 32'h0);
    chk("t3_bypass", rd_data[XLEN +: XLEN], 32'h55);
    step(); idle();
    #1 chk("t3_release", 32'(busy_vec[7]), 32'h0);

    // 4: saturation
    issue_en = 1; issue_rd = 3;
    repeat (3) step();
    #1 chk("t4_stall", 32'(issue_stall), 32'h1);
    step();
    #1 chk("t4_still_sat", 32'(issue_stall), 32'h1);
    wb_en = 1; wb_rd = 3; wb_data = 32'h33;
    #1 chk("t4_wb_unstall", 32'(issue_stall), 32'h0);
    step(); wb_en = 0;
    #1 chk("t4_pend3", 32'(issue_stall), 32'h1);
    idle();

    // 5: partial drain, flush, orphan write-back
    issue_en = 1; issue_rd = 9;
    repeat (2) step();
    idle(); wb_en = 1; wb_rd = 9; wb_data = 32'h99;
    step(); idle(); rd_addr[0 +: AW] = 9;
    #1 chk("t5_busy_p1", 32'(rd_busy[0]), 32'h1);
    flush = 1;
    step(); idle();
    #1 chk("t5_flush", busy_vec, 32'h0);
    wb_en = 1; wb_rd = 9; wb_data = 32'hA5A5;
    step(); idle();
    #1 chk("t5_sberr", 32'(sb_err), 32'h1);
    chk("t5_written", rd_data[0 +: XLEN], 32'hA5A5);

    // 6: issue+wb same cycle from pend=1, then async reset
    do_reset();
    issue_en = 1; issue_rd = 4;
    step();
    wb_en = 1; wb_rd = 4; wb_data = 32'h44;
    step(); idle(); rd_addr[0 +: AW] = 4;
    #1 chk("t6_pend1", 32'(busy_vec[4]), 32'h1);
    chk("t6_busy", 32'(rd_busy[0]), 32'h1);
    wb_en = 1; wb_rd = 4; wb_data = 32'h77; issue_en = 1; issue_rd = 4;
    #1 rst = 0; m_clear();
    #1 chk("t6_rst_data", 32'(rd_data[0 +: XLEN]), 32'h0);
    chk("t6_rst_busy", 32'(rd_busy), 32'h0);
    chk("t6_rst_vec", busy_vec, 32'h0);
    chk("t6_rst_stall", 32'(issue_stall), 32'h0);
    idle();
    @(posedge clk); #1 rst = 1;

    // Random phase over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      int cand [$];
      if ($urandom_range(0, 399) == 0) do_reset();
      issue_en = $urandom_range(0, 99) < 40;
      issue_rd = AW'($urandom_range(0, 7));
      wb_en    = $urandom_range(0, 99) < 45;
      for (int r = 1; r < 8; r++) if (m_pend[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 99) < 80)
        wb_rd = AW'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wb_rd = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = $urandom_range(0, 99) < 2;
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 99) < 30) ? wb_rd : AW'($urandom_range(0, 7));
      step();
    end

    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
